// File: rtl/hpdcache_pkg.sv
// rtl/hpdcache_pkg.sv - shared HPDcache request/response types and tid width
package hpdcache_pkg;

  localparam int HPDCACHE_TID_W = 3;

  typedef logic [HPDCACHE_TID_W-1:0] hpdcache_tid_t;

  typedef struct packed {
    logic [15:0]   addr;
    logic [1:0]    op;
    logic          need_rsp;
    hpdcache_tid_t tid;
  } hpdcache_req_t;

  typedef struct packed {
    hpdcache_tid_t tid;
    logic [15:0]   data;
    logic          error;
  } hpdcache_rsp_t;

endpackage

// File: rtl/hwpf_stride_rsp_demux_if.sv
// rtl/hwpf_stride_rsp_demux_if.sv - request/response bundle between arbiter, cache and prefetchers
interface hwpf_stride_rsp_demux_if #(
  parameter int NUM_HW_PREFETCH = 4
);
  import hpdcache_pkg::*;

  localparam int ID_W = (NUM_HW_PREFETCH > 1) ? $clog2(NUM_HW_PREFETCH) : 1;

  logic                                    arb_req_valid_i;
  logic                                    arb_req_ready_o;
  logic [ID_W-1:0]                         arb_req_id_i;
  hpdcache_req_t                           arb_req_i;
  logic                                    cache_req_valid_o;
  logic                                    cache_req_ready_i;
  hpdcache_req_t                           cache_req_o;
  logic                                    cache_rsp_valid_i;
  hpdcache_rsp_t                           cache_rsp_i;
  logic [NUM_HW_PREFETCH-1:0]              hwpf_rsp_valid_o;
  logic [NUM_HW_PREFETCH-1:0]              hwpf_rsp_ready_i;
  hpdcache_rsp_t [NUM_HW_PREFETCH-1:0]     hwpf_rsp_o;

  // demux side
  modport master (
    input  arb_req_valid_i, arb_req_id_i, arb_req_i, cache_req_ready_i,
    input  cache_rsp_valid_i, cache_rsp_i, hwpf_rsp_ready_i,
    output arb_req_ready_o, cache_req_valid_o, cache_req_o,
    output hwpf_rsp_valid_o, hwpf_rsp_o
  );

  // arbiter / cache / prefetcher side
  modport slave (
    output arb_req_valid_i, arb_req_id_i, arb_req_i, cache_req_ready_i,
    output cache_rsp_valid_i, cache_rsp_i, hwpf_rsp_ready_i,
    input  arb_req_ready_o, cache_req_valid_o, cache_req_o,
    input  hwpf_rsp_valid_o, hwpf_rsp_o
  );

endinterface

// File: rtl/hpdcache_fifo_reg.sv
// rtl/hpdcache_fifo_reg.sv - register FIFO with occupancy counter for full/empty
module hpdcache_fifo_reg #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rptr_q];

  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // storage needs no reset; occupancy decides what is valid
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/hwpf_stride_rsp_demux.sv
// rtl/hwpf_stride_rsp_demux.sv - prefetch tid stamping, response credits and per-prefetcher demux (option: HWPF_STRIDE_RSP_DEMUX_ERR_CHK_EN)
module hwpf_stride_rsp_demux
  import hpdcache_pkg::*;
#(
  parameter int NUM_HW_PREFETCH = 4,
  parameter int RSP_FIFO_DEPTH  = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  hwpf_stride_rsp_demux_if.master         bus,
  output logic                            err_o
);

  localparam int ID_W  = (NUM_HW_PREFETCH > 1) ? $clog2(NUM_HW_PREFETCH) : 1;
  localparam int CNT_W = $clog2(RSP_FIFO_DEPTH) + 1;

  logic [CNT_W-1:0] inflight_q;
  logic             credit_ok, inc, push, pop;
  logic             fifo_full, fifo_empty;
  hpdcache_rsp_t    head;
  logic             head_tid_ok, head_ready;
  logic [ID_W-1:0]  req_id;

  assign req_id = bus.arb_req_id_i;

  // a request that expects no response never consumes a FIFO slot
  assign credit_ok             = (inflight_q < CNT_W'(RSP_FIFO_DEPTH)) | ~bus.arb_req_i.need_rsp;
  assign bus.cache_req_valid_o = bus.arb_req_valid_i & credit_ok;
  assign bus.arb_req_ready_o   = bus.cache_req_ready_i & credit_ok;

  // stamp the issuing prefetcher index into the tid
  always_comb begin
    bus.cache_req_o     = bus.arb_req_i;
    bus.cache_req_o.tid = HPDCACHE_TID_W'(req_id);
  end

  assign inc  = bus.arb_req_valid_i & bus.cache_req_ready_i & credit_ok & bus.arb_req_i.need_rsp;
  assign push = bus.cache_rsp_valid_i & (inflight_q != '0);

  // responses outstanding at the cache plus entries waiting in the FIFO
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
    end else if (inc && !pop) begin
      inflight_q <= inflight_q + CNT_W'(1);
    end else if (!inc && pop && inflight_q != '0) begin
      inflight_q <= inflight_q - CNT_W'(1);
    end
  end

  hpdcache_fifo_reg #(
    .DEPTH (RSP_FIFO_DEPTH),
    .WIDTH ($bits(hpdcache_rsp_t))
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (bus.cache_rsp_i),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // steer the head to its prefetcher; an unknown tid is silently consumed
  always_comb begin
    bus.hwpf_rsp_valid_o = '0;
    head_tid_ok          = 1'b0;
    head_ready           = 1'b0;
    for (int i = 0; i < NUM_HW_PREFETCH; i++) begin
      bus.hwpf_rsp_o[i] = head;
      if (head.tid == HPDCACHE_TID_W'(i)) begin
        head_tid_ok             = 1'b1;
        bus.hwpf_rsp_valid_o[i] = ~fifo_empty;
        head_ready              = bus.hwpf_rsp_ready_i[i];
      end
    end
    pop = ~fifo_empty & (~head_tid_ok | head_ready);
  end

`ifdef HWPF_STRIDE_RSP_DEMUX_ERR_CHK_EN
  logic drop_ev, overflow_ev, bad_tid_ev, err_q;

  assign drop_ev     = bus.cache_rsp_valid_i & (inflight_q == '0);
  assign overflow_ev = push & fifo_full & ~pop;
  assign bad_tid_ev  = ~fifo_empty & ~head_tid_ok;

  // sticky until reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (drop_ev || overflow_ev || bad_tid_ev) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  a_no_drop: assert property (@(posedge clk_i) disable iff (!rst_ni) !drop_ev)
    else $error("response dropped with no request in flight");
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !overflow_ev)
    else $error("response pushed into a full FIFO");
  a_tid_ok: assert property (@(posedge clk_i) disable iff (!rst_ni) !bad_tid_ev)
    else $error("response tid outside prefetcher range");
`else
  logic fifo_full_unused;
  assign fifo_full_unused = fifo_full;
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_hwpf_stride_rsp_demux.sv
// tb/tb_hwpf_stride_rsp_demux.sv - self-checking bench for hwpf_stride_rsp_demux
module tb_hwpf_stride_rsp_demux;
  import hpdcache_pkg::*;

  localparam int NUM   = 4;
  localparam int DEPTH = 4;
  localparam int ID_W  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;

  always #5 clk = ~clk;

  hwpf_stride_rsp_demux_if #(.NUM_HW_PREFETCH(NUM)) bus ();

  hwpf_stride_rsp_demux #(
    .NUM_HW_PREFETCH (NUM),
    .RSP_FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus),
    .err_o  (err)
  );

  int checks = 0;
  int errors = 0;

  // reference model: response queue, credit count, sticky error
  hpdcache_rsp_t mq[$];
  int            m_inflight = 0;
  bit            m_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_inflight = 0;
    m_err = 1'b0;
  endtask

  task automatic set_idle();
    bus.arb_req_valid_i   = 1'b0;
    bus.arb_req_id_i      = '0;
    bus.arb_req_i         = '0;
    bus.cache_req_ready_i = 1'b0;
    bus.cache_rsp_valid_i = 1'b0;
    bus.cache_rsp_i       = '0;
    bus.hwpf_rsp_ready_i  = '0;
  endtask

  function automatic bit credit();
    return (m_inflight < DEPTH) || !bus.arb_req_i.need_rsp;
  endfunction

  task automatic compare();
    hpdcache_req_t    er;
    logic [NUM-1:0]   ev;
    bit               cr;
    cr = credit();
    chk("cache_req_valid", 64'(bus.cache_req_valid_o), 64'(bus.arb_req_valid_i & cr));
    chk("arb_req_ready", 64'(bus.arb_req_ready_o), 64'(bus.cache_req_ready_i & cr));
    if (bus.arb_req_valid_i) begin
      er = bus.arb_req_i;
      er.tid = 3'(bus.arb_req_id_i);
      chk("cache_req", 64'(bus.cache_req_o), 64'(er));
    end
    ev = '0;
    if (mq.size() > 0 && int'(mq[0].tid) < NUM) ev[mq[0].tid] = 1'b1;
    chk("hwpf_rsp_valid", 64'(bus.hwpf_rsp_valid_o), 64'(ev));
    if (ev != '0) begin
      for (int i = 0; i < NUM; i++) chk("hwpf_rsp", 64'(bus.hwpf_rsp_o[i]), 64'(mq[0]));
    end
    chk("err", 64'(err), 64'(m_err));
  endtask

  task automatic update();
    bit pop, push, inc;
    int tmp;
    if (!rst_n) begin
      model_clear();
      return;
    end
    inc  = bus.arb_req_valid_i && bus.cache_req_ready_i && credit() && bus.arb_req_i.need_rsp;
    pop  = mq.size() > 0 && (int'(mq[0].tid) >= NUM || bus.hwpf_rsp_ready_i[mq[0].tid]);
    push = bus.cache_rsp_valid_i && m_inflight != 0;
`ifdef HWPF_STRIDE_RSP_DEMUX_ERR_CHK_EN
    if (bus.cache_rsp_valid_i && m_inflight == 0) m_err = 1'b1;
    if (push && mq.size() == DEPTH && !pop) m_err = 1'b1;
    if (mq.size() > 0 && int'(mq[0].tid) >= NUM) m_err = 1'b1;
`endif
    tmp = m_inflight + (inc ? 1 : 0);
    if (pop && tmp > 0) tmp--;
    m_inflight = tmp;
    if (pop) void'(mq.pop_front());
    if (push && mq.size() < DEPTH) mq.push_back(bus.cache_rsp_i);
  endtask

  // inputs are set just after a falling edge; check, then advance one cycle
  task automatic tick();
    #1;
    compare();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic req(input int id, input bit need);
    hpdcache_req_t r;
    r.addr     = 16'($urandom);
    r.op       = 2'($urandom);
    r.need_rsp = need;
    r.tid      = 3'($urandom);
    bus.arb_req_valid_i   = 1'b1;
    bus.arb_req_id_i      = ID_W'(id);
    bus.arb_req_i         = r;
    bus.cache_req_ready_i = 1'b1;
  endtask

  task automatic rsp(input int tid, input logic [15:0] data);
    bus.cache_rsp_valid_i = 1'b1;
    bus.cache_rsp_i.tid   = 3'(tid);
    bus.cache_rsp_i.data  = data;
    bus.cache_rsp_i.error = 1'b0;
  endtask

  function automatic logic exp_err_sticky();
`ifdef HWPF_STRIDE_RSP_DEMUX_ERR_CHK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    set_idle();
    model_clear();
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    #1;
    chk("rst_arb_ready", 64'(bus.arb_req_ready_o), 64'd0);
    chk("rst_cache_valid", 64'(bus.cache_req_valid_o), 64'd0);
    chk("rst_hwpf_valid", 64'(bus.hwpf_rsp_valid_o), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // single round trip
    req(2, 1'b1);
    #1;
    chk("rt_tid", 64'(bus.cache_req_o.tid), 64'd2);
    chk("rt_req_valid", 64'(bus.cache_req_valid_o), 64'd1);
    tick();
    set_idle();
    repeat (3) tick();
    rsp(2, 16'hbeef);
    tick();
    set_idle();
    #1;
    chk("rt_rsp_valid", 64'(bus.hwpf_rsp_valid_o), 64'b0100);
    chk("rt_rsp_data", 64'(bus.hwpf_rsp_o[2].data), 64'hbeef);
    bus.hwpf_rsp_ready_i = 4'b0100;
    tick();
    set_idle();
    #1;
    chk("rt_popped", 64'(bus.hwpf_rsp_valid_o), 64'd0);
    // inflight is back to 0, so this response is dropped
    rsp(1, 16'h1111);
    tick();
    set_idle();
    #1;
    chk("drop_valid", 64'(bus.hwpf_rsp_valid_o), 64'd0);
    chk("drop_err", 64'(err), 64'(exp_err_sticky()));
    tick();
    #1;
    chk("drop_err_sticky", 64'(err), 64'(exp_err_sticky()));
    rst_n = 1'b0;
    model_clear();
    tick();
    rst_n = 1'b1;
    #1;
    chk("err_cleared", 64'(err), 64'd0);
    tick();

    // credit stall and need_rsp=0 bypass
    for (int k = 0; k < 4; k++) begin
      req(k, 1'b1);
      tick();
    end
    req(0, 1'b1);
    #1;
    chk("stall_ready", 64'(bus.arb_req_ready_o), 64'd0);
    chk("stall_valid", 64'(bus.cache_req_valid_o), 64'd0);
    tick();
    req(3, 1'b0);
    #1;
    chk("bypass_ready", 64'(bus.arb_req_ready_o), 64'd1);
    tick();
    req(0, 1'b1);
    rsp(1, 16'h2001);
    tick();
    bus.cache_rsp_valid_i = 1'b0;
    bus.hwpf_rsp_ready_i  = 4'b1111;
    #1;
    chk("still_stalled", 64'(bus.arb_req_ready_o), 64'd0);
    tick();
    bus.hwpf_rsp_ready_i = 4'b0000;
    #1;
    chk("resume_ready", 64'(bus.arb_req_ready_o), 64'd1);
    tick();
    set_idle();
    bus.hwpf_rsp_ready_i = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      rsp(k, 16'(16'h2100 + k));
      tick();
    end
    bus.cache_rsp_valid_i = 1'b0;
    repeat (2) tick();
    set_idle();

    // head-of-line blocking
    req(1, 1'b1);
    tick();
    req(3, 1'b1);
    tick();
    set_idle();
    bus.hwpf_rsp_ready_i = 4'b1000;
    rsp(1, 16'h3001);
    tick();
    rsp(3, 16'h3003);
    tick();
    bus.cache_rsp_valid_i = 1'b0;
    #1;
    chk("hol_block", 64'(bus.hwpf_rsp_valid_o), 64'b0010);
    tick();
    bus.hwpf_rsp_ready_i = 4'b1010;
    #1;
    chk("hol_still", 64'(bus.hwpf_rsp_valid_o), 64'b0010);
    tick();
    #1;
    chk("hol_next", 64'(bus.hwpf_rsp_valid_o), 64'b1000);
    tick();
    #1;
    chk("hol_empty", 64'(bus.hwpf_rsp_valid_o), 64'd0);
    set_idle();
    tick();

    // full FIFO with simultaneous push and pop
    for (int k = 0; k < 4; k++) begin
      req(k, 1'b1);
      tick();
    end
    set_idle();
    for (int k = 0; k < 4; k++) begin
      rsp(k, 16'(16'h4000 + k));
      tick();
    end
    bus.cache_rsp_valid_i = 1'b0;
    #1;
    chk("full_head", 64'(bus.hwpf_rsp_valid_o), 64'b0001);
    rsp(2, 16'h4444);
    bus.hwpf_rsp_ready_i = 4'b0001;
    tick();
    set_idle();
    #1;
    chk("full_next", 64'(bus.hwpf_rsp_valid_o), 64'b0010);
    chk("full_data", 64'(bus.hwpf_rsp_o[1].data), 64'h4001);
    chk("full_err", 64'(err), 64'd0);
    bus.hwpf_rsp_ready_i = 4'b1111;
    repeat (6) tick();
    set_idle();

    // head tid outside prefetcher range is discarded
    rst_n = 1'b0;
    model_clear();
    tick();
    rst_n = 1'b1;
    req(0, 1'b1);
    tick();
    set_idle();
    rsp(5, 16'h5005);
    tick();
    set_idle();
    #1;
    chk("bad_tid_valid", 64'(bus.hwpf_rsp_valid_o), 64'd0);
    tick();
    #1;
    chk("bad_tid_gone", 64'(bus.hwpf_rsp_valid_o), 64'd0);
    rst_n = 1'b0;
    model_clear();
    tick();
    rst_n = 1'b1;
    tick();

    // randomized traffic with a mid-run reset
    for (int c = 0; c < 4000; c++) begin
      hpdcache_req_t r;
      int outst;
      if (c == 2000) begin
        rst_n = 1'b0;
        model_clear();
      end
      if (c == 2002) rst_n = 1'b1;
      r.addr     = 16'($urandom);
      r.op       = 2'($urandom);
      r.need_rsp = ($urandom_range(0, 3) != 0);
      r.tid      = 3'($urandom);
      bus.arb_req_valid_i   = 1'($urandom_range(0, 1));
      bus.arb_req_id_i      = ID_W'($urandom_range(0, NUM - 1));
      bus.arb_req_i         = r;
      bus.cache_req_ready_i = ($urandom_range(0, 9) < 7);
      outst = m_inflight - mq.size();
      bus.cache_rsp_valid_i = (outst > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) < 3);
      bus.cache_rsp_i.tid   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(NUM, 7)) : 3'($urandom_range(0, NUM - 1));
      bus.cache_rsp_i.data  = 16'($urandom);
      bus.cache_rsp_i.error = 1'($urandom);
      bus.hwpf_rsp_ready_i  = 4'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
